memory_unit: RTL

- Sits between the pipelined core datapath and a single Wishbone-style classic bus master port.
- Serialises, per pipeline step, one optional data access (MEM stage) and one instruction fetch (IF stage) onto the shared bus.
- Returns the fetched instruction and the read data to the datapath.
- Holds mem_busy high until both accesses complete, which freezes every pipeline register.

---
 rtl/memory_unit_pkg.sv | 21 ++
 rtl/memory_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/memory_unit_pkg.sv
// Shared types and sizing helpers for memory_unit, the core-side bus
// serialiser that puts data accesses and instruction fetches on one bus.
package memory_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA_REQ = 2'd1,
    ST_INST_REQ = 2'd2,
    ST_DONE     = 2'd3
  } mem_unit_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  // The counter must be able to hold TIMEOUT_CYCLES itself.
  function automatic int tmo_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int TMO_CNT_W_DEF = tmo_cnt_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/memory_unit.sv
// Serialises one optional data access and one instruction fetch per pipeline
// step onto a classic bus. Optional ack timeout: define MEMORY_UNIT_TIMEOUT_EN.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   inst_mem_addr,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_SIZE-1:0]   data_mem_addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  logic [DATA_SIZE/8-1:0] byte_en,
  output logic [31:0]            inst,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   mem_busy,
  output logic                   bus_cyc,
  output logic                   bus_stb,
  output logic                   bus_we,
  output logic [DATA_SIZE-1:0]   bus_addr,
  output logic [DATA_SIZE/8-1:0] bus_sel,
  output logic [DATA_SIZE-1:0]   bus_dat_o,
  input  logic [DATA_SIZE-1:0]   bus_dat_i,
  input  logic                   bus_ack,
  output logic                   bus_error
);

  localparam int SEL_W = DATA_SIZE / 8;

  if ((DATA_SIZE != 32 && DATA_SIZE != 64) || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("memory_unit: unsupported DATA_SIZE or TIMEOUT_CYCLES");
  end

  mem_unit_state_t r_state, w_state_next;

  logic [DATA_SIZE-1:0] r_pc, r_daddr, r_wdata, r_rd_data;
  logic [SEL_W-1:0]     r_sel;
  logic                 r_we;
  logic [31:0]          r_inst;

  logic w_in_data, w_in_inst, w_access, w_abort, w_step;

  assign w_in_data = (r_state == ST_DATA_REQ);
  assign w_in_inst = (r_state == ST_INST_REQ);
  assign w_access  = w_in_data | w_in_inst;

`ifdef MEMORY_UNIT_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Abort wins over a same-cycle ack: the strobe is already dropped then.
  assign w_abort = w_access && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       r_tmo_cnt <= '0;
    else if (w_state_next != r_state) r_tmo_cnt <= '0;
    else if (w_access)               r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_abort = 1'b0;
`endif

  assign w_step = w_access && (w_abort || bus_ack);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // The data access goes first: the MEM-stage instruction is older than IF.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     w_state_next = (rd_en | wr_en) ? ST_DATA_REQ : ST_INST_REQ;
      ST_DATA_REQ: if (w_step) w_state_next = ST_INST_REQ;
      ST_INST_REQ: if (w_step) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_daddr   <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_rd_data <= '0;
      r_inst    <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_pc    <= inst_mem_addr;
        r_daddr <= data_mem_addr;
        r_wdata <= wr_data;
        r_sel   <= byte_en;
        r_we    <= wr_en;
      end
      // Simultaneous rd_en/wr_en is a write, so read data stays untouched.
      if (w_in_data && w_step && !r_we)
        r_rd_data <= w_abort ? '0 : bus_dat_i;
      if (w_in_inst && w_step)
        r_inst <= w_abort ? '0 : bus_dat_i[31:0];
    end
  end

  assign bus_cyc   = w_access & ~w_abort;
  assign bus_stb   = w_access & ~w_abort;
  assign bus_we    = w_in_data & r_we;
  assign bus_addr  = w_in_data ? r_daddr : (w_in_inst ? r_pc : '0);
  assign bus_sel   = w_in_data ? r_sel : (w_in_inst ? {SEL_W{1'b1}} : '0);
  assign bus_dat_o = w_in_data ? r_wdata : '0;
  assign bus_error = w_abort;

  assign mem_busy = (r_state != ST_DONE);
  assign inst     = r_inst;
  assign rd_data  = r_rd_data;

endmodule
